ioctl_sdram_writer: RTL and testbench

- Sits between the HPS ioctl download port and the SDRAM controller.
- Packs the ROM byte stream into 32-bit little-endian words and writes each word to SDRAM through the controller's req/ack handshake.
- A small word FIFO absorbs SDRAM back-pressure.
- Reports busy, done and overflow so the top level can hold the game core in reset until the ROM is fully in SDRAM.

---
 rtl/ioctl_sdram_writer.sv | 171 +++++++++++++++++
 tb/tb_ioctl_sdram_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_writer.sv
// ioctl_sdram_writer
//   Takes the HPS ioctl ROM download byte stream, packs it into 32-bit
//   little-endian words and writes each word to SDRAM through the
//   controller's req/ack handshake. A small word FIFO absorbs SDRAM
//   back-pressure. busy/done let the top level hold the core in reset
//   until the whole ROM has landed in SDRAM.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   ioctl_addr/data/wr    download byte address, byte, one-cycle strobe
//   ioctl_download        high for the whole download
//   sdram_addr/data       word address / word data of the FIFO head
//   sdram_req, sdram_we   request (FIFO non-empty); we mirrors req
//   sdram_ack             controller accepted the head word this cycle
//   busy                  download or drain in progress
//   done                  one-cycle pulse once the last word is accepted
//   overflow              sticky: a word was dropped on a full FIFO
module ioctl_sdram_writer #(
    parameter int ADDR_WIDTH = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    input  logic                  ioctl_download,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]           sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t state, state_nxt;

    logic                  dl_q;
    logic                  dl_rise, dl_fall;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic [1:0]            wr_lane;
    logic [31:0]           fresh_word;

    logic [ADDR_WIDTH-1:0] asm_addr;
    logic [31:0]           asm_data;
    logic                  asm_valid, asm_full;

    logic                  push, pop, push_ok;
    logic                  fifo_empty, fifo_full;
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [31:0]           mem_data [FIFO_DEPTH];

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign wr_en   = ioctl_wr & (state == S_LOAD);

    // Upper byte-address bits beyond the SDRAM word space are dropped (wrap).
    assign wr_word    = ioctl_addr[ADDR_WIDTH+1:2];
    assign wr_lane    = ioctl_addr[1:0];
    assign fresh_word = {24'd0, ioctl_data} << {wr_lane, 3'b000};

    // The FLUSH term catches a byte that arrived in the same cycle as the
    // download falling edge, so no word is ever left stranded.
    assign push = asm_valid & (asm_full
                             | (wr_en & (wr_word != asm_addr))
                             | dl_fall
                             | (state == S_FLUSH));

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = sdram_req & sdram_ack;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok    = push & (~fifo_full | pop);

    // Head is gated by empty so the outputs read 0 as soon as reset empties the FIFO.
    assign sdram_req  = ~fifo_empty;
    assign sdram_we   = sdram_req;
    assign sdram_addr = fifo_empty ? '0 : mem_addr[rd_ptr[PTR_W-1:0]];
    assign sdram_data = fifo_empty ? '0 : mem_data[rd_ptr[PTR_W-1:0]];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            dl_q  <= ioctl_download;
        end
    end

    // NOTE: next state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dl_rise) state_nxt = S_LOAD;
            S_LOAD:  if (dl_fall) state_nxt = S_FLUSH;
            S_FLUSH: if (fifo_empty && !asm_valid) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Assembly register: a push always ships the old word; a byte arriving
    // with the push (or into an empty register) starts a fresh zeroed word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_addr  <= '0;
            asm_data  <= '0;
            asm_valid <= 1'b0;
            asm_full  <= 1'b0;
        end else if (dl_rise) begin
            asm_addr  <= '0;
            asm_data  <= '0;
            asm_valid <= 1'b0;
            asm_full  <= 1'b0;
        end else if (wr_en) begin
            if (push || !asm_valid) begin
                asm_addr  <= wr_word;
                asm_data  <= fresh_word;
                asm_valid <= 1'b1;
            end else begin
                asm_data[{wr_lane, 3'b000} +: 8] <= ioctl_data;
            end
            // Lane 3 completes the word; it is pushed on the following cycle.
            asm_full <= (wr_lane == 2'd3);
        end else if (push) begin
            asm_valid <= 1'b0;
            asm_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers and
    // the head outputs are masked while empty, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr[PTR_W-1:0]] <= asm_addr;
            mem_data[wr_ptr[PTR_W-1:0]] <= asm_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            overflow <= 1'b0;
        else if (dl_rise)                        overflow <= 1'b0;
        else if (push && fifo_full && !pop)      overflow <= 1'b1;
    end

endmodule

// File: tb/tb_ioctl_sdram_writer.sv
module tb_ioctl_sdram_writer;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic          ioctl_wr = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [AW-1:0] sdram_addr;
    logic [31:0]   sdram_data;
    logic          sdram_we, sdram_req;
    logic          sdram_ack = 1'b0;
    logic          busy, done, overflow;

    always #5 clk = ~clk;

    ioctl_sdram_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .busy(busy), .done(done), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records every accepted SDRAM write and every done cycle.
    logic [AW-1:0] cap_addr [256];
    logic [31:0]   cap_data [256];
    int cap_n = 0;
    int done_cnt = 0;
    int we_bad = 0;

    always @(negedge clk) begin
        if (sdram_req && sdram_ack && cap_n < 256) begin
            cap_addr[cap_n] <= sdram_addr;
            cap_data[cap_n] <= sdram_data;
            cap_n <= cap_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (sdram_we !== sdram_req) we_bad <= we_bad + 1;
    end

    typedef struct packed {
        logic [3:0]        nb;
        logic [7:0][24:0]  a;
        logic [7:0][7:0]   d;
        logic [1:0]        nw;
        logic [1:0][22:0]  wa;
        logic [1:0][31:0]  wd;
    } vec_t;

    vec_t vecs [3];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        cyc(2);
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        cyc(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        cyc(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        cyc(1);
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] b0, input int w);
        logic [7:0] b;
        b = b0 + 8'(4 * w);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic run_row(input int r, input string tag);
        int base_cap, base_done;
        sdram_ack = 1'b1;
        base_cap  = cap_n;
        base_done = done_cnt;
        start_dl();
        for (int i = 0; i < int'(vecs[r].nb); i++) wr_byte(vecs[r].a[i], vecs[r].d[i]);
        end_dl();
        wait_done({tag, "_done_seen"}, 200);
        cyc(3);
        check({tag, "_nwords"}, cap_n - base_cap, vecs[r].nw);
        for (int w = 0; w < int'(vecs[r].nw); w++) begin
            check($sformatf("%s_addr%0d", tag, w), cap_addr[base_cap + w], vecs[r].wa[w]);
            check($sformatf("%s_data%0d", tag, w), cap_data[base_cap + w], vecs[r].wd[w]);
        end
        check({tag, "_done_once"}, done_cnt - base_done, 1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_no_ovf"}, overflow, 1'b0);
    endtask

    // Drives n consecutive bytes addr 0..n-1, data b0+i, ack held low.
    task automatic stream(input int n, input logic [7:0] b0);
        sdram_ack = 1'b0;
        start_dl();
        for (int i = 0; i < n; i++) wr_byte(25'(i), b0 + 8'(i));
        end_dl();
    endtask

    initial begin
        int base_cap, base_done, unstable;

        vecs[0] = '0;
        vecs[0].nb = 4'd8;
        for (int i = 0; i < 8; i++) begin
            vecs[0].a[i] = 25'(i);
            vecs[0].d[i] = 8'(17 * (i + 1));
        end
        vecs[0].nw = 2'd2;
        vecs[0].wa[0] = 23'd0; vecs[0].wd[0] = 32'h44332211;
        vecs[0].wa[1] = 23'd1; vecs[0].wd[1] = 32'h88776655;

        vecs[1] = vecs[0];
        vecs[1].nb = 4'd6;
        vecs[1].wd[1] = 32'h00006655;

        vecs[2] = '0;
        vecs[2].nb = 4'd3;
        vecs[2].a[0] = 25'd0; vecs[2].d[0] = 8'hAA;
        vecs[2].a[1] = 25'd1; vecs[2].d[1] = 8'hBB;
        vecs[2].a[2] = 25'd8; vecs[2].d[2] = 8'hCC;
        vecs[2].nw = 2'd2;
        vecs[2].wa[0] = 23'd0; vecs[2].wd[0] = 32'h0000BBAA;
        vecs[2].wa[1] = 23'd2; vecs[2].wd[1] = 32'h000000CC;

        // Reset state
        #12;
        check("rst_req", sdram_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_addr", sdram_addr, '0);
        check("rst_data", sdram_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);

        // Table-driven single downloads with ack tied high
        for (int r = 0; r < 3; r++) run_row(r, $sformatf("row%0d", r));

        // Lane-3 latency: req rises two cycles after the lane-3 strobe
        sdram_ack = 1'b0;
        base_cap = cap_n;
        start_dl();
        ioctl_addr = 25'd3; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        @(negedge clk);
        check("lat_req_c1", sdram_req, 1'b0);
        @(negedge clk);
        check("lat_req_c2", sdram_req, 1'b1);
        check("lat_addr", sdram_addr, 23'd0);
        check("lat_data", sdram_data, 32'h5A000000);
        cyc(1);
        end_dl();
        sdram_ack = 1'b1;
        wait_done("lat_done_seen", 100);
        cyc(2);
        check("lat_nwords", cap_n - base_cap, 1);

        // Back-pressure: 16 bytes fill the FIFO exactly
        base_cap = cap_n;
        base_done = done_cnt;
        stream(16, 8'h10);
        @(negedge clk);
        check("bp_req", sdram_req, 1'b1);
        check("bp_head_addr", sdram_addr, 23'd0);
        check("bp_head_data", sdram_data, exp_word(8'h10, 0));
        unstable = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sdram_addr !== 23'd0 || sdram_data !== exp_word(8'h10, 0) || !sdram_req) unstable++;
        end
        check("bp_stable", unstable, 0);
        check("bp_ovf", overflow, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_no_done", done_cnt - base_done, 0);
        cyc(1);
        sdram_ack = 1'b1;
        wait_done("bp_done_seen", 100);
        cyc(2);
        check("bp_nwords", cap_n - base_cap, 4);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("bp_addr%0d", w), cap_addr[base_cap + w], 23'(w));
            check($sformatf("bp_data%0d", w), cap_data[base_cap + w], exp_word(8'h10, w));
        end

        // Overflow: 24 bytes with ack low, two words dropped
        base_cap = cap_n;
        stream(24, 8'h40);
        cyc(10);
        check("ovf_set", overflow, 1'b1);
        check("ovf_head_addr", sdram_addr, 23'd0);
        sdram_ack = 1'b1;
        wait_done("ovf_done_seen", 100);
        cyc(2);
        check("ovf_nwords", cap_n - base_cap, 4);
        for (int w = 0; w < 4; w++)
            check($sformatf("ovf_data%0d", w), cap_data[base_cap + w], exp_word(8'h40, w));
        check("ovf_sticky", overflow, 1'b1);

        // Asynchronous reset in the middle of a stalled drain
        stream(24, 8'h60);
        cyc(5);
        check("mid_pre_req", sdram_req, 1'b1);
        check("mid_pre_ovf", overflow, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", sdram_req, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_data", sdram_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);
        run_row(0, "post_rst");

        check("we_eq_req", we_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
